// File: rtl/snake_pkg.sv
// Shared constants for the snake game display path: game states,
// directions, grid geometry, 640x480@60 VGA timing, colours, scan FSM.
package snake_pkg;

  localparam logic [1:0] GS_RUNNING = 2'b00;
  localparam logic [1:0] GS_DIE     = 2'b01;
  localparam logic [1:0] GS_INITIAL = 2'b10;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int GRID_W  = 32;
  localparam int GRID_H  = 24;
  localparam int CELL    = 20;
  localparam int MAX_LEN = 64;

  localparam logic [4:0] CELL_LAST = 5'(CELL - 1);
  localparam logic [5:0] COL_LAST  = 6'(GRID_W - 1);
  localparam logic [4:0] ROW_LAST  = 5'(GRID_H - 1);

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_FP     = 10'd16;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BP     = 10'd48;
  localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_FP     = 10'd10;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BP     = 10'd33;
  localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] COL_BLACK    = 12'h000;
  localparam logic [11:0] COL_WHITE    = 12'hFFF;
  localparam logic [11:0] COL_FOOD     = 12'hF00;
  localparam logic [11:0] COL_HEAD_RUN = 12'h0A0;
  localparam logic [11:0] COL_HEAD_DIE = 12'hF80;
  localparam logic [11:0] COL_BODY_RUN = 12'h0F0;
  localparam logic [11:0] COL_BODY_DIE = 12'h840;
  localparam logic [11:0] COL_GRID     = 12'h222;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_CAPTURE,
    SCAN_CLEAR,
    SCAN_FILL
  } scan_t;

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 counters, cell sub-counters, raw syncs, active, frame_start.
// Ports: clk, rst (async active-low) in; h, v, cell_x/y, active, grid,
// hs_raw, vs_raw, frame_start out. Grid flag only with VGA_GRID_EN.
module vga_timing
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic [5:0] cell_x,
  output logic [4:0] cell_y,
  output logic       active,
  output logic       grid,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       frame_start
);

  localparam logic [9:0] HS_BEG = H_ACTIVE + H_FP;
  localparam logic [9:0] HS_END = HS_BEG + H_SYNC;
  localparam logic [9:0] VS_BEG = V_ACTIVE + V_FP;
  localparam logic [9:0] VS_END = VS_BEG + V_SYNC;

  logic [4:0] px_x;
  logic [4:0] px_y;
  logic       h_end;
  logic       v_end;

  assign h_end = (h == H_TOTAL - 10'd1);
  assign v_end = (v == V_TOTAL - 10'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h      <= '0;
      v      <= '0;
      px_x   <= '0;
      px_y   <= '0;
      cell_x <= '0;
      cell_y <= '0;
    end else begin
      if (h_end) begin
        h      <= '0;
        px_x   <= '0;
        cell_x <= '0;
      end else begin
        h <= h + 10'd1;
        if (px_x == CELL_LAST) begin
          px_x   <= '0;
          cell_x <= cell_x + 6'd1;
        end else begin
          px_x <= px_x + 5'd1;
        end
      end
      if (h_end) begin
        if (v_end) begin
          v      <= '0;
          px_y   <= '0;
          cell_y <= '0;
        end else begin
          v <= v + 10'd1;
          if (px_y == CELL_LAST) begin
            px_y   <= '0;
            cell_y <= cell_y + 5'd1;
          end else begin
            px_y <= px_y + 5'd1;
          end
        end
      end
    end
  end

  assign active      = (h < H_ACTIVE) && (v < V_ACTIVE);
  assign hs_raw      = !((h >= HS_BEG) && (h < HS_END));
  assign vs_raw      = !((v >= VS_BEG) && (v < VS_END));
  assign frame_start = (h == 10'd0) && (v == 10'd0);

`ifdef VGA_GRID_EN
  assign grid = (px_x == 5'd0) || (px_y == 5'd0);
`else
  assign grid = 1'b0;
`endif

endmodule

// File: rtl/vga_render.sv
// Snake display: vblank snapshot + 32x24 bitmap rebuild, RGB444 out.
// Ports: clk, rst (async active-low), game inputs in; vga, syncs,
// frame_start out (2-cycle pipe). Optional grid lines: VGA_GRID_EN.
module vga_render
  import snake_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             game_state,
  input  logic [5:0]             snake_length,
  input  logic [5*MAX_LEN-1:0]   snake_x_1dim,
  input  logic [5*MAX_LEN-1:0]   snake_y_1dim,
  input  logic [4:0]             food_x,
  input  logic [4:0]             food_y,
  output logic [11:0]            vga,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   frame_start
);

  localparam logic [5:0] CLR_LAST = 6'(GRID_H - 1);

  logic [9:0] t_h;
  logic [9:0] t_v;
  logic [5:0] t_cell_x;
  logic [4:0] t_cell_y;
  logic       t_active;
  logic       t_grid;
  logic       t_hs;
  logic       t_vs;
  logic       t_fs;

  vga_timing u_timing (
    .clk         (clk),
    .rst         (rst),
    .h           (t_h),
    .v           (t_v),
    .cell_x      (t_cell_x),
    .cell_y      (t_cell_y),
    .active      (t_active),
    .grid        (t_grid),
    .hs_raw      (t_hs),
    .vs_raw      (t_vs),
    .frame_start (t_fs)
  );

  logic                 snap_vld;
  logic [1:0]           snap_state;
  logic [5:0]           snap_len;
  logic [5*MAX_LEN-1:0] snap_x;
  logic [5*MAX_LEN-1:0] snap_y;
  logic [4:0]           snap_fx;
  logic [4:0]           snap_fy;

  logic [GRID_W-1:0] bitmap [GRID_H];

  scan_t      state;
  scan_t      state_nxt;
  logic [5:0] idx;
  logic [5:0] idx_nxt;
  logic [8:0] seg_base;
  logic [4:0] fill_x;
  logic [4:0] fill_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SCAN_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      SCAN_IDLE: begin
        if (t_h == 10'd0 && t_v == V_ACTIVE)
          state_nxt = SCAN_CAPTURE;
      end
      SCAN_CAPTURE: begin
        state_nxt = SCAN_CLEAR;
        idx_nxt   = '0;
      end
      SCAN_CLEAR: begin
        if (idx == CLR_LAST) begin
          idx_nxt   = '0;
          state_nxt = (snap_len == 6'd0) ? SCAN_IDLE : SCAN_FILL;
        end else begin
          idx_nxt = idx + 6'd1;
        end
      end
      SCAN_FILL: begin
        if (idx == snap_len - 6'd1) begin
          idx_nxt   = '0;
          state_nxt = SCAN_IDLE;
        end else begin
          idx_nxt = idx + 6'd1;
        end
      end
      default: state_nxt = SCAN_IDLE;
    endcase
  end

  assign seg_base = 9'(idx) * 9'd5;
  assign fill_x   = snap_x[seg_base +: 5];
  assign fill_y   = snap_y[seg_base +: 5];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_vld   <= 1'b0;
      snap_state <= '0;
      snap_len   <= '0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_fx    <= '0;
      snap_fy    <= '0;
    end else if (state == SCAN_CAPTURE) begin
      snap_vld   <= 1'b1;
      snap_state <= game_state;
      snap_len   <= snake_length;
      snap_x     <= snake_x_1dim;
      snap_y     <= snake_y_1dim;
      snap_fx    <= food_x;
      snap_fy    <= food_y;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < GRID_H; r++)
        bitmap[r] <= '0;
    end else if (state == SCAN_CLEAR) begin
      bitmap[idx[4:0]] <= '0;
    end else if (state == SCAN_FILL && fill_y <= ROW_LAST) begin
      bitmap[fill_y][fill_x] <= 1'b1;
    end
  end

  logic bm_bit;
  logic ring;
  logic food_hit;
  logic head_hit;

  always_comb begin
    bm_bit = 1'b0;
    if (t_active)
      bm_bit = bitmap[t_cell_y][t_cell_x[4:0]];
  end

  assign ring = (t_cell_x == 6'd0) || (t_cell_x == COL_LAST) ||
                (t_cell_y == 5'd0) || (t_cell_y == ROW_LAST);
  assign food_hit = (t_cell_x == {1'b0, snap_fx}) &&
                    (t_cell_y == snap_fy);
  assign head_hit = (snap_len != 6'd0) &&
                    (t_cell_x == {1'b0, snap_x[4:0]}) &&
                    (t_cell_y == snap_y[4:0]);

  logic s1_act, s1_vld, s1_init, s1_die;
  logic s1_ring, s1_food, s1_head, s1_body, s1_grid;
  logic s1_hs, s1_vs, s1_fs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_act  <= 1'b0;
      s1_vld  <= 1'b0;
      s1_init <= 1'b0;
      s1_die  <= 1'b0;
      s1_ring <= 1'b0;
      s1_food <= 1'b0;
      s1_head <= 1'b0;
      s1_body <= 1'b0;
      s1_grid <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
      s1_fs   <= 1'b0;
    end else begin
      s1_act  <= t_active;
      s1_vld  <= snap_vld;
      s1_init <= (snap_state == GS_INITIAL) || (snap_state == 2'b11);
      s1_die  <= (snap_state == GS_DIE);
      s1_ring <= ring;
      s1_food <= food_hit;
      s1_head <= head_hit;
      s1_body <= bm_bit;
      s1_grid <= t_grid;
      s1_hs   <= t_hs;
      s1_vs   <= t_vs;
      s1_fs   <= t_fs;
    end
  end

  logic [11:0] col;

  // Before the first rebuild the snapshot is all zeros, which would
  // otherwise paint a food cell at (0,0); hold the play area black.
  always_comb begin
    col = COL_BLACK;
    if (!s1_act || !s1_vld)
      col = COL_BLACK;
    else if (s1_init)
      col = s1_ring ? COL_WHITE : COL_BLACK;
    else if (s1_food)
      col = COL_FOOD;
    else if (s1_head)
      col = s1_die ? COL_HEAD_DIE : COL_HEAD_RUN;
    else if (s1_body)
      col = s1_die ? COL_BODY_DIE : COL_BODY_RUN;
    else if (s1_grid)
      col = COL_GRID;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga         <= COL_BLACK;
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga         <= col;
      h_sync      <= s1_hs;
      v_sync      <= s1_vs;
      frame_start <= s1_fs;
    end
  end

endmodule
